// File: rtl/uart_pkg.sv
// Shared UART TX types and line-level constants.
// UART_TX_TWO_STOP_EN adds the STOP2 state to the TX state enum.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
`ifdef UART_TX_TWO_STOP_EN
        ,
        STOP2  = 3'd5
`endif
    } tx_state_e;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and data-bit counter for the UART TX framer.
// done is high during the cycle in which the last data bit is on the line.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    output logic [DATA_WIDTH-1:0] shift_data,
    output logic                  lsb,
    output logic                  next_bit,
    output logic                  done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;

    // The register is not shifted on the START->DATA edge, so cnt_q equals
    // the index of the data bit currently on the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= load_data;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= shift_q >> 1;
            cnt_q   <= done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign done       = (cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign shift_data = shift_q;
    assign lsb        = shift_q[0];
    assign next_bit   = shift_q[1];

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to append a second stop bit to every frame.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    tx_state_e state_q, state_d;

    logic par_en_q, par_typ_q, par_bit_q;
    logic tx_q, tx_d;
    logic busy_q, busy_d;
    logic load, shift_en;

    logic [DATA_WIDTH-1:0] ser_data;
    logic                  ser_lsb, ser_next, ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .load_data (P_DATA),
        .shift_en  (shift_en),
        .shift_data(ser_data),
        .lsb       (ser_lsb),
        .next_bit  (ser_next),
        .done      (ser_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (load) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
            // Shift register still holds the whole latched byte during START.
            if (state_q == START)
                par_bit_q <= (par_typ_q == PAR_ODD) ? ~^ser_data : ^ser_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START:  state_d = DATA;
            DATA: begin
                shift_en = 1'b1;
                if (ser_done)
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:   state_d = STOP2;
            STOP2:  state_d = IDLE;
`else
            STOP:   state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state and registered.
    always_comb begin
        tx_d = IDLE_LEVEL;
        case (state_d)
            IDLE:   tx_d = IDLE_LEVEL;
            START:  tx_d = START_BIT;
            DATA:   tx_d = (state_q == START) ? ser_lsb : ser_next;
            PARITY: tx_d = par_bit_q;
            STOP:   tx_d = STOP_BIT;
`ifdef UART_TX_TWO_STOP_EN
            STOP2:  tx_d = STOP_BIT;
`endif
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a frame-level model queues expected
// line sequences; a negedge monitor compares TX_OUT/busy against them.
module tb_uart_tx_frame;

    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = '0;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       busy;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    frame_t exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     busy_left = 0;

    uart_tx_frame #(
        .DATA_WIDTH(DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Line sequence as the receiver sees it: start, data LSB first,
    // parity making the total count of ones even (or odd), stop bits.
    function automatic frame_t build(input logic [7:0] d, input logic pe, input logic pt);
        frame_t f;
        int ones;
        ones   = 0;
        f.bits = '0;
        f.len  = 0;
        f.bits[f.len] = 1'b0;
        f.len++;
        for (int i = 0; i < DW; i++) begin
            f.bits[f.len] = d[i];
            f.len++;
            ones += int'(d[i]);
        end
        if (pe) begin
            f.bits[f.len] = ((ones % 2) == 1) ^ pt;
            f.len++;
        end
        for (int s = 0; s < NSTOP; s++) begin
            f.bits[f.len] = 1'b1;
            f.len++;
        end
        return f;
    endfunction

    // Acceptance model: a request is taken only when the previous frame
    // and its trailing idle edge are over.
    always @(posedge CLK or negedge RST) begin
        frame_t f;
        if (!RST) begin
            busy_left = 0;
            exp_q.delete();
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (DATA_VALID) begin
            f = build(P_DATA, PAR_EN, PAR_TYP);
            exp_q.push_back(f);
            busy_left = f.len;
        end
    end

    frame_t cur;
    int     idx = 0;
    bit     in_frame = 1'b0;
    bit     expect_idle = 1'b0;

    always @(negedge CLK) begin
        if (!RST) begin
            in_frame    = 1'b0;
            expect_idle = 1'b0;
            check("reset_tx", TX_OUT, 1'b1);
            check("reset_busy", busy, 1'b0);
        end else if (in_frame) begin
            check("frame_bit", TX_OUT, cur.bits[idx]);
            check("frame_busy", busy, 1'b1);
            idx++;
            if (idx >= cur.len) begin
                in_frame    = 1'b0;
                expect_idle = 1'b1;
            end
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("start_bit", TX_OUT, cur.bits[0]);
            check("start_busy", busy, 1'b1);
            idx      = 1;
            in_frame = 1'b1;
        end else begin
            check(expect_idle ? "gap_tx" : "idle_tx", TX_OUT, 1'b1);
            check(expect_idle ? "gap_busy" : "idle_busy", busy, 1'b0);
            expect_idle = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    initial begin
        #1 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        idle(3);

        send(8'hA5, 1'b1, 1'b0);
        idle(14);
        send(8'hA5, 1'b1, 1'b1);
        idle(14);
        send(8'hA5, 1'b0, 1'b0);
        idle(14);
        send(8'h00, 1'b1, 1'b0);
        idle(14);

        // Request and config changes during a frame must be dropped.
        send(8'hA5, 1'b1, 1'b0);
        idle(2);
        DATA_VALID = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        P_DATA     = 8'h0F;
        idle(14);

        // Request held high: back-to-back frames with one idle cycle between.
        @(negedge CLK);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        repeat (30) begin
            @(negedge CLK);
            P_DATA = 8'($urandom);
        end
        DATA_VALID = 1'b0;
        idle(16);

        // Asynchronous reset during data bit 4, then a clean frame.
        send(8'h5A, 1'b1, 1'b1);
        repeat (5) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("rst_async_tx", TX_OUT, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        idle(2);
        send(8'hC3, 1'b1, 1'b0);
        idle(14);

        repeat (600) begin
            @(negedge CLK);
            DATA_VALID = ($urandom % 4) == 0;
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
        end
        DATA_VALID = 1'b0;
        idle(20);

        tests++;
        if (exp_q.size() != 0 || in_frame) begin
            fails++;
            $display("FAIL drain: pending=%0d in_frame=%0d expected 0 and 0", exp_q.size(), in_frame);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
